ring_token_scheduler: RTL and testbench

- Round-robin scheduler that shares one resource between NUM_REQ requesters using a one-hot rotating token (a ring counter).
- Issues one registered one-hot grant at a time.
- Enforces a maximum burst length per grant, then advances the token past the last owner.
- Sits in front of shared datapath blocks, for example a single counter or output port shared by several masters.

---
 rtl/ring_sched_pkg.sv | 42 ++++
 rtl/ring_priority_pick.sv | 27 ++
 rtl/ring_token_scheduler.sv | 106 ++++++++++
 tb/tb_ring_token_scheduler.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ring_sched_pkg.sv
// Shared types and helpers for the ring token scheduler.
// Helpers work on a fixed maximum-width vector so any NUM_REQ up to MAX_REQ can use them.
package ring_sched_pkg;

  localparam int MAX_REQ = 32;

  typedef logic [MAX_REQ-1:0] req_vec_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Binary index of a one-hot vector; returns 0 for an all-zero vector.
  function automatic int unsigned onehot_to_idx(input req_vec_t v);
    int unsigned idx;
    idx = 32'd0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (v[i]) begin
        idx = idx | i;
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Rotate the low n bits of v left by one; bit n-1 wraps to bit 0.
  function automatic req_vec_t rotl1(input req_vec_t v, input int unsigned n);
    req_vec_t r;
    r = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (i < n) begin
        r[(i + 32'd1) % n] = v[i];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ring_priority_pick.sv
// Combinational round-robin pick: first set req bit at or above the token, wrapping.
// Uses a double-width vector so the wrap-around search is a single lowest-bit isolate.
module ring_priority_pick
  import ring_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] token,
  output logic [NUM_REQ-1:0] winner,
  output logic               any_req
);

  logic [2*NUM_REQ-1:0] below_s;
  logic [2*NUM_REQ-1:0] masked_s;
  logic [2*NUM_REQ-1:0] lowest_s;

  // Lower copy keeps only bits at/above the token; upper copy supplies the wrapped bits.
  always_comb begin
    below_s  = {{NUM_REQ{1'b0}}, token} - {{(2*NUM_REQ-1){1'b0}}, 1'b1};
    masked_s = {req, req} & ~below_s;
    lowest_s = masked_s & (~masked_s + {{(2*NUM_REQ-1){1'b0}}, 1'b1});
    winner   = lowest_s[NUM_REQ-1:0] | lowest_s[2*NUM_REQ-1:NUM_REQ];
    any_req  = |req;
  end

endmodule

// File: rtl/ring_token_scheduler.sv
// Round-robin scheduler with a one-hot rotating token, burst limit and registered grant.
// One dead cycle always separates consecutive grants.
module ring_token_scheduler
  import ring_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 8,
  localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [NUM_REQ-1:0] token,
  output logic [CNT_W-1:0]   burst_cnt
);

  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  state_t             state_r;
  logic [NUM_REQ-1:0] token_r;
  logic [NUM_REQ-1:0] grant_r;
  logic               grant_valid_r;
  logic [IDX_W-1:0]   grant_idx_r;
  logic [CNT_W-1:0]   burst_cnt_r;

  logic [NUM_REQ-1:0] winner_s;
  logic               any_req_s;
  logic               release_s;

  ring_priority_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req     (req),
    .token   (token_r),
    .winner  (winner_s),
    .any_req (any_req_s)
  );

  // Owner release: its done pulse, its request dropping, or the burst limit while enabled.
  always_comb begin
    release_s = ~(|(req & grant_r)) | (|(done & grant_r))
              | (enable & (burst_cnt_r == BURST_LAST));
  end

  // Scheduler FSM, token ring, burst counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      token_r       <= {{(NUM_REQ-1){1'b0}}, 1'b1};
      grant_r       <= '0;
      grant_valid_r <= 1'b0;
      grant_idx_r   <= '0;
      burst_cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (enable && any_req_s) begin
            state_r       <= GRANT;
            token_r       <= winner_s;
            grant_r       <= winner_s;
            grant_valid_r <= 1'b1;
            grant_idx_r   <= IDX_W'(onehot_to_idx(MAX_REQ'(winner_s)));
            burst_cnt_r   <= '0;
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT: begin
          if (release_s) begin
            // Token equals the owner here, so rotating it moves past the last owner.
            state_r       <= IDLE;
            token_r       <= NUM_REQ'(rotl1(MAX_REQ'(token_r), NUM_REQ));
            grant_r       <= '0;
            grant_valid_r <= 1'b0;
            grant_idx_r   <= '0;
            burst_cnt_r   <= '0;
          end else if (enable) begin
            burst_cnt_r <= burst_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            burst_cnt_r <= burst_cnt_r;
          end
        end
        default: begin
          state_r       <= IDLE;
          grant_r       <= '0;
          grant_valid_r <= 1'b0;
          grant_idx_r   <= '0;
          burst_cnt_r   <= '0;
        end
      endcase
    end
  end

  assign grant       = grant_r;
  assign grant_valid = grant_valid_r;
  assign grant_idx   = grant_idx_r;
  assign token       = token_r;
  assign burst_cnt   = burst_cnt_r;

endmodule

// File: tb/tb_ring_token_scheduler.sv
// Directed bench for ring_token_scheduler (NUM_REQ=4, MAX_BURST=4).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_ring_token_scheduler;

  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 4;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_idx;
  logic [3:0] token;
  logic [1:0] burst_cnt;

  int n_checks;
  int n_fail;

  ring_token_scheduler #(
    .NUM_REQ   (NUM_REQ),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .token       (token),
    .burst_cnt   (burst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check full observable state: grant, derived valid/index, token and burst count.
  task automatic chk_state(input string tag, input logic [3:0] g, input logic [3:0] t,
                           input logic [1:0] c);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) idx = 2'(i);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".valid"}, 32'(grant_valid), 32'(|g));
    chk({tag, ".idx"}, 32'(grant_idx), 32'(idx));
    chk({tag, ".token"}, 32'(token), 32'(t));
    chk({tag, ".cnt"}, 32'(burst_cnt), 32'(c));
  endtask

  // Structural invariants sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && n_checks > 0) begin
      n_checks++;
      assert ($onehot0(grant)) else begin
        n_fail++;
        $error("FAIL onehot0_grant: observed %b expected zero or one-hot", grant);
      end
      n_checks++;
      assert ($onehot(token)) else begin
        n_fail++;
        $error("FAIL onehot_token: observed %b expected one-hot", token);
      end
    end
  end

  initial begin
    logic [3:0] g_exp;
    n_checks = 0;
    n_fail   = 0;
    rst    = 1'b1;
    enable = 1'b1;
    req    = 4'b1111;
    done   = 4'b0000;

    // Reset held two cycles with all requests pending.
    step();
    step();
    chk_state("reset", 4'b0000, 4'b0001, 2'd0);
    rst = 1'b0;
    step();
    chk_state("first_grant", 4'b0001, 4'b0001, 2'd0);

    // Fairness: each owner keeps 4 cycles, then one dead cycle and the token moves on.
    for (int g = 0; g < 4; g++) begin
      g_exp = 4'b0001 << g;
      for (int c = 0; c < 4; c++) begin
        chk_state($sformatf("fair_g%0d_c%0d", g, c), g_exp, g_exp, 2'(c));
        step();
      end
      chk_state($sformatf("fair_gap%0d", g), 4'b0000, 4'b0001 << ((g + 1) % 4), 2'd0);
      step();
    end
    chk_state("fair_wrap", 4'b0001, 4'b0001, 2'd0);

    // Early release via done at burst_cnt=1; owner still requesting.
    step();
    chk_state("early_cnt1", 4'b0001, 4'b0001, 2'd1);
    done = 4'b0001;
    req  = 4'b0101;
    step();
    chk_state("early_rel", 4'b0000, 4'b0010, 2'd0);
    done = 4'b0000;
    req  = 4'b0100;
    step();
    chk_state("early_next", 4'b0100, 4'b0100, 2'd0);

    // Release by request drop, then wrap from token 1000 to requester 1.
    req = 4'b0000;
    step();
    chk_state("drop_rel", 4'b0000, 4'b1000, 2'd0);
    req = 4'b0010;
    step();
    chk_state("wrap_grant", 4'b0010, 4'b0010, 2'd0);
    req = 4'b0000;
    step();
    chk_state("wrap_rel", 4'b0000, 4'b0100, 2'd0);

    // Enable freeze mid-grant; a non-owner done must not preempt.
    req = 4'b1111;
    step();
    chk_state("frz_grant", 4'b0100, 4'b0100, 2'd0);
    step();
    step();
    chk_state("frz_cnt2", 4'b0100, 4'b0100, 2'd2);
    enable = 1'b0;
    done   = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_state($sformatf("frz_hold%0d", k), 4'b0100, 4'b0100, 2'd2);
    end
    enable = 1'b1;
    done   = 4'b0000;
    step();
    chk_state("frz_cnt3", 4'b0100, 4'b0100, 2'd3);
    step();
    chk_state("frz_rel", 4'b0000, 4'b1000, 2'd0);

    // Disabled IDLE grants nothing, then grants on enable.
    enable = 1'b0;
    step();
    chk_state("idle_dis", 4'b0000, 4'b1000, 2'd0);
    enable = 1'b1;
    step();
    chk_state("idle_en", 4'b1000, 4'b1000, 2'd0);

    // Reset while requester 2 holds the grant.
    req = 4'b0100;
    step();
    chk_state("pre_rst_rel", 4'b0000, 4'b0001, 2'd0);
    step();
    chk_state("pre_rst_grant", 4'b0100, 4'b0100, 2'd0);
    rst = 1'b1;
    step();
    chk_state("mid_rst", 4'b0000, 4'b0001, 2'd0);
    rst = 1'b0;
    req = 4'b0000;
    step();
    chk_state("post_rst", 4'b0000, 4'b0001, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
